// File: rtl/fsmc_read_slave.sv
// fsmc_read_slave: FPGA-side responder for STM32 FSMC asynchronous read cycles.
// Synchronises the FSMC pins, fetches the addressed word from the register
// file through a request/valid handshake, drives it onto the bus until the MCU
// ends the cycle, and counts completed reads.
//
// Register-file handshake: rd_req is a single-cycle pulse with rd_adr valid in
// that cycle (rd_adr then holds until the next request). rd_valid/rd_data may
// answer in the request cycle itself or any later cycle; a response is only
// accepted while a fetch is outstanding, otherwise it is ignored. If no
// response arrives within TIMEOUT cycles, FILL is driven and timeout_err pulses.
module fsmc_read_slave #(
  parameter int              AW      = 2,
  parameter int              DW      = 8,
  parameter int              TIMEOUT = 15,
  parameter logic [DW-1:0]   FILL    = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          aNE,
  input  logic          aNOE,
  input  logic          aNWE,
  input  logic [AW-1:0] aA,
  output logic          rd_req,
  output logic [AW-1:0] rd_adr,
  input  logic [DW-1:0] rd_data,
  input  logic          rd_valid,
  output logic [DW-1:0] d_out,
  output logic          d_oe,
  output logic          timeout_err,
  output logic [7:0]    rd_count
);

  localparam int          TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  // Control bits ordered {NE, NOE, NWE}; idle bus level is all high.
  logic [2:0]    ctl_meta_q, ctl_sync_q;
  logic [AW-1:0] adr_meta_q, adr_sync_q;
  logic          rd_cond;

  state_t        state_q, state_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_adr_q, rd_adr_d;
  logic [DW-1:0] d_out_q, d_out_d;
  logic          d_oe_q, d_oe_d;
  logic          timeout_err_q, timeout_err_d;
  logic [7:0]    rd_count_q, rd_count_d;
  logic [TW-1:0] timer_q, timer_d;

  // Two-flop synchronisers for every asynchronous FSMC pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_meta_q <= 3'b111;
      ctl_sync_q <= 3'b111;
      adr_meta_q <= '0;
      adr_sync_q <= '0;
    end else begin
      ctl_meta_q <= {aNE, aNOE, aNWE};
      ctl_sync_q <= ctl_meta_q;
      adr_meta_q <= aA;
      adr_sync_q <= adr_meta_q;
    end
  end

  // Read cycle: chip selected, output enable low, write enable high.
  assign rd_cond = ~ctl_sync_q[2] & ~ctl_sync_q[1] & ctl_sync_q[0];

  // Next-state and registered-output logic for the read FSM.
  always_comb begin
    state_d       = state_q;
    rd_req_d      = 1'b0;
    rd_adr_d      = rd_adr_q;
    d_out_d       = d_out_q;
    d_oe_d        = d_oe_q;
    timeout_err_d = 1'b0;
    rd_count_d    = rd_count_q;
    timer_d       = timer_q;
    case (state_q)
      S_IDLE: begin
        d_oe_d = 1'b0;
        if (rd_cond) begin
          state_d  = S_FETCH;
          rd_adr_d = adr_sync_q;
          rd_req_d = 1'b1;
          timer_d  = '0;
        end
      end
      S_FETCH: begin
        if (!rd_cond) begin
          // MCU abandoned the cycle: never drive, never count.
          state_d = S_IDLE;
          d_oe_d  = 1'b0;
        end else if (rd_valid) begin
          // Data beats the timeout even when both land in the same cycle.
          d_out_d    = rd_data;
          d_oe_d     = 1'b1;
          rd_count_d = rd_count_q + 8'd1;
          state_d    = S_DRIVE;
        end else if (timer_q == LAST) begin
          d_out_d       = FILL;
          d_oe_d        = 1'b1;
          timeout_err_d = 1'b1;
          rd_count_d    = rd_count_q + 8'd1;
          state_d       = S_DRIVE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DRIVE: begin
        d_oe_d = 1'b1;
        // Any loss of the read condition (including NWE going low) releases the bus.
        if (!rd_cond) begin
          d_oe_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        d_oe_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset drops d_oe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rd_req_q      <= 1'b0;
      rd_adr_q      <= '0;
      d_out_q       <= '0;
      d_oe_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      rd_count_q    <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      rd_req_q      <= rd_req_d;
      rd_adr_q      <= rd_adr_d;
      d_out_q       <= d_out_d;
      d_oe_q        <= d_oe_d;
      timeout_err_q <= timeout_err_d;
      rd_count_q    <= rd_count_d;
      timer_q       <= timer_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_adr      = rd_adr_q;
  assign d_out       = d_out_q;
  assign d_oe        = d_oe_q;
  assign timeout_err = timeout_err_q;
  assign rd_count    = rd_count_q;

endmodule

// File: tb/tb_fsmc_read_slave.sv
// Testbench for fsmc_read_slave: table of directed reads, hand-written corner
// sequences (abort, write cycle, reset while driving) and 256 randomised reads
// checked against a transaction-level model of the read protocol.
module tb_fsmc_read_slave;

  localparam int AW      = 2;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;
  localparam logic [DW-1:0] FILL = 8'hFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          aNE = 1'b1, aNOE = 1'b1, aNWE = 1'b1;
  logic [AW-1:0] aA = '0;
  logic          rd_req;
  logic [AW-1:0] rd_adr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [DW-1:0] d_out;
  logic          d_oe;
  logic          timeout_err;
  logic [7:0]    rd_count;

  fsmc_read_slave #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .FILL(FILL)) dut (
    .clk(clk), .rst(rst), .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE), .aA(aA),
    .rd_req(rd_req), .rd_adr(rd_adr), .rd_data(rd_data), .rd_valid(rd_valid),
    .d_out(d_out), .d_oe(d_oe), .timeout_err(timeout_err), .rd_count(rd_count)
  );

  // ---------------- register-file responder ----------------
  // rf_delay: cycles after the rd_req cycle at which rd_valid fires (0 = same
  // cycle, negative = never answer).
  logic [DW-1:0] mem [4];
  int            rf_delay   = 0;
  int            rf_cnt     = 0;
  logic          rf_pending = 1'b0;

  assign rd_data  = mem[rd_adr];
  assign rd_valid = (rf_delay >= 0) &&
                    ((rf_delay == 0) ? rd_req : (rf_pending && rf_cnt == rf_delay));

  always @(posedge clk) begin
    if (rd_valid) rf_pending <= 1'b0;
    else if (rd_req) begin
      rf_pending <= 1'b1;
      rf_cnt     <= 1;
    end else if (rf_pending) rf_cnt <= rf_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [7:0]    exp_count = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one complete FSMC read ----------------
  task automatic do_read(input logic [AW-1:0] adr, input int delay,
                         input logic [DW-1:0] exp_data, input logic exp_to,
                         input int exp_oe_lat);
    int n;
    int to_cnt;
    int req_cnt;
    logic [DW-1:0] held;
    rf_delay = delay;
    aA = adr; aNWE = 1'b1; aNE = 1'b0; aNOE = 1'b0;
    n = 0; to_cnt = 0; req_cnt = 0;
    do begin step(); n++; end while (!rd_req && n < 10);
    check("req_latency", n, 3);
    check("rd_adr", rd_adr, adr);
    if (rd_req) req_cnt = 1;
    n = 0;
    while (!d_oe && n < 40) begin
      step(); n++;
      if (rd_req) req_cnt++;
      if (timeout_err) to_cnt++;
    end
    check("oe_latency", n, exp_oe_lat);
    check("req_pulses", req_cnt, 1);
    check("d_out", d_out, exp_data);
    held = d_out;
    step();
    if (timeout_err) to_cnt++;
    check("d_oe_hold", d_oe, 1'b1);
    check("d_out_hold", d_out, held);
    check("timeout_pulses", to_cnt, exp_to);
    exp_count = exp_count + 8'd1;
    check("rd_count", rd_count, exp_count);
    aNOE = 1'b1; aNE = 1'b1;
    n = 0;
    do begin step(); n++; end while (d_oe && n < 10);
    check("release_latency", n, 3);
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [AW-1:0] adr;
    int            delay;
    logic [DW-1:0] word;
    logic [DW-1:0] exp_data;
    logic          exp_to;
    int            exp_oe_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    int d;
    logic [AW-1:0] a;
    logic          seen;

    vecs[0] = '{adr: 2'd2, delay: 0,  word: 8'hA5, exp_data: 8'hA5, exp_to: 1'b0, exp_oe_lat: 1};
    vecs[1] = '{adr: 2'd1, delay: 5,  word: 8'h3C, exp_data: 8'h3C, exp_to: 1'b0, exp_oe_lat: 6};
    vecs[2] = '{adr: 2'd3, delay: -1, word: 8'h12, exp_data: 8'hFF, exp_to: 1'b1, exp_oe_lat: 15};
    vecs[3] = '{adr: 2'd0, delay: 14, word: 8'h5A, exp_data: 8'h5A, exp_to: 1'b0, exp_oe_lat: 15};
    vecs[4] = '{adr: 2'd2, delay: 15, word: 8'h77, exp_data: 8'hFF, exp_to: 1'b1, exp_oe_lat: 15};
    vecs[5] = '{adr: 2'd0, delay: 1,  word: 8'h00, exp_data: 8'h00, exp_to: 1'b0, exp_oe_lat: 2};

    for (int i = 0; i < 4; i++) mem[i] = 8'h00;

    // Reset state
    #1;
    check("rst_d_oe", d_oe, 1'b0);
    check("rst_d_out", d_out, 8'h00);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_rd_adr", rd_adr, 2'd0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_rd_count", rd_count, 8'h00);
    step(); step();
    rst = 1'b0;
    step(); step();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      mem[vecs[i].adr] = vecs[i].word;
      do_read(vecs[i].adr, vecs[i].delay, vecs[i].exp_data, vecs[i].exp_to, vecs[i].exp_oe_lat);
    end

    // Abort: NOE rises one clock into FETCH; late rd_valid must be ignored.
    mem[1] = 8'hC3;
    rf_delay = 6;
    aA = 2'd1; aNWE = 1'b1; aNE = 1'b0; aNOE = 1'b0;
    n = 0;
    do begin step(); n++; end while (!rd_req && n < 10);
    check("abort_req_seen", rd_req, 1'b1);
    aNOE = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (d_oe || timeout_err) seen = 1'b1;
    end
    check("abort_no_drive", seen, 1'b0);
    check("abort_rd_count", rd_count, exp_count);
    aNE = 1'b1;
    step(); step();

    // Write cycle must never request a read.
    aA = 2'd3; aNE = 1'b0; aNWE = 1'b0; aNOE = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rd_req || d_oe) seen = 1'b1;
    end
    check("write_no_req", seen, 1'b0);
    aNE = 1'b1; aNWE = 1'b1;
    step(); step();

    // Reset asserted while driving: d_oe must drop without waiting for a clock.
    mem[3] = 8'h9E;
    rf_delay = 0;
    aA = 2'd3; aNE = 1'b0; aNOE = 1'b0;
    n = 0;
    do begin step(); n++; end while (!d_oe && n < 20);
    check("rstdrv_d_oe_up", d_oe, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rstdrv_d_oe", d_oe, 1'b0);
    check("rstdrv_d_out", d_out, 8'h00);
    check("rstdrv_rd_adr", rd_adr, 2'd0);
    check("rstdrv_rd_count", rd_count, 8'h00);
    check("rstdrv_timeout_err", timeout_err, 1'b0);
    aNE = 1'b1; aNOE = 1'b1;
    step(); step();
    rst = 1'b0;
    exp_count = 8'd0;
    step(); step();

    // 256 randomised back-to-back reads, addresses cycling 0..3.
    for (int i = 0; i < 256; i++) begin
      a = AW'(i % 4);
      mem[a] = 8'($urandom_range(0, 255));
      d = int'($urandom_range(0, 17));
      if (d == 17) d = -1;
      // Model: an answer within the first TIMEOUT fetch cycles wins; else FILL.
      if (d >= 0 && d < TIMEOUT) exp_q.push_back(mem[a]);
      else exp_q.push_back(FILL);
      do_read(a, d, exp_q.pop_front(), !(d >= 0 && d < TIMEOUT),
              (d >= 0 && d < TIMEOUT) ? d + 1 : TIMEOUT);
    end
    check("count_wrap", rd_count, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
